vgroup_uop_sequencer: RTL and testbench

- Sequencer in the decode/issue stage that expands one grouped vector instruction (LMUL>1) into per-register micro-ops, one per handshake.
- For each micro-op it drives base register + index for vs1/vs2/vd into the vector ALU path.
- Holds the front end (IF1/IF2/decode) via stall_fetch until the last micro-op issues.
- Replaces the combinational cnt feedback loop with a self-contained FSM and valid/ready handshake.

---
 rtl/vgroup_uop_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_vgroup_uop_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vgroup_uop_sequencer.sv
// Expands one grouped vector instruction (LMUL>1) into per-register micro-ops over a valid/ready handshake.
// Optional macro VGROUP_VL_TRIM_EN adds in_vl_regs and trims the group to min(N, in_vl_regs).
module vgroup_uop_sequencer #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_AW-1:0] in_raA,
   input  logic [REG_AW-1:0] in_raB,
   input  logic [REG_AW-1:0] in_rdest,
   input  logic [2:0]        in_lmul,
`ifdef VGROUP_VL_TRIM_EN
   input  logic [3:0]        in_vl_regs,
`endif
   output logic              uop_valid,
   input  logic              uop_ready,
   output logic [REG_AW-1:0] uop_raA,
   output logic [REG_AW-1:0] uop_raB,
   output logic [REG_AW-1:0] uop_rdest,
   output logic [CNT_W-1:0]  uop_idx,
   output logic              uop_first,
   output logic              uop_last,
   output logic              stall_fetch,
   output logic              done,
   output logic              illegal_lmul
);

   localparam int NW = (CNT_W + 1 > 4) ? CNT_W + 1 : 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [NW-1:0]   n_s;
   logic [NW-1:0]   eff_s;
   logic            illegal_s;
   logic            accept_s;
   logic            hs_s;
   logic            last_hs_s;
   logic [CNT_W-1:0] last_idx_r;

   // Reserved encoding 100 decodes to zero; fractional LMUL still needs one micro-op.
   function automatic logic [NW-1:0] lmul_count(input logic [2:0] lmul);
      logic [NW-1:0] cnt;
      case (lmul)
         3'b000:  cnt = NW'(4'd1);
         3'b001:  cnt = NW'(4'd2);
         3'b010:  cnt = NW'(4'd4);
         3'b011:  cnt = NW'(4'd8);
         3'b100:  cnt = NW'(4'd0);
         default: cnt = NW'(4'd1);
      endcase
      return cnt;
   endfunction

   // Decode of the offered instruction: group size and legality.
   always_comb begin
      n_s       = lmul_count(in_lmul);
      illegal_s = (in_lmul == 3'b100);
`ifdef VGROUP_VL_TRIM_EN
      if (NW'(in_vl_regs) < n_s) begin
         eff_s = NW'(in_vl_regs);
      end else begin
         eff_s = n_s;
      end
`else
      eff_s = n_s;
`endif
      accept_s  = in_valid && in_ready;
      hs_s      = uop_valid && uop_ready;
      last_hs_s = hs_s && uop_last;
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; flush wins over any handshake or acceptance.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (flush) begin
               state_nxt_s = IDLE;
            end else if (accept_s && !illegal_s && (eff_s != {NW{1'b0}})) begin
               state_nxt_s = ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            if (flush || last_hs_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = ISSUE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Handshake-facing outputs decoded from state; front end resumes on the final acceptance.
   always_comb begin
      uop_valid   = 1'b0;
      in_ready    = 1'b0;
      stall_fetch = 1'b0;
      case (state_r)
         IDLE: begin
            uop_valid   = 1'b0;
            in_ready    = !flush;
            stall_fetch = 1'b0;
         end
         ISSUE: begin
            uop_valid   = 1'b1;
            in_ready    = 1'b0;
            stall_fetch = !(uop_last && uop_ready);
         end
         default: begin
            uop_valid   = 1'b0;
            in_ready    = 1'b0;
            stall_fetch = 1'b0;
         end
      endcase
   end

   // Micro-op datapath: addresses advance by one per handshake and wrap modulo 2^REG_AW.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         uop_raA      <= {REG_AW{1'b0}};
         uop_raB      <= {REG_AW{1'b0}};
         uop_rdest    <= {REG_AW{1'b0}};
         uop_idx      <= {CNT_W{1'b0}};
         uop_first    <= 1'b0;
         uop_last     <= 1'b0;
         last_idx_r   <= {CNT_W{1'b0}};
         done         <= 1'b0;
         illegal_lmul <= 1'b0;
      end else if (flush) begin
         uop_idx      <= {CNT_W{1'b0}};
         uop_first    <= 1'b0;
         uop_last     <= 1'b0;
         done         <= 1'b0;
         illegal_lmul <= 1'b0;
      end else begin
         done         <= 1'b0;
         illegal_lmul <= 1'b0;
         if (accept_s) begin
            if (illegal_s) begin
               illegal_lmul <= 1'b1;
            end else if (eff_s == {NW{1'b0}}) begin
               done <= 1'b1;
            end else begin
               uop_raA    <= in_raA;
               uop_raB    <= in_raB;
               uop_rdest  <= in_rdest;
               uop_idx    <= {CNT_W{1'b0}};
               uop_first  <= 1'b1;
               uop_last   <= (eff_s == NW'(4'd1));
               last_idx_r <= CNT_W'(eff_s - NW'(4'd1));
            end
         end else if (hs_s) begin
            if (uop_last) begin
               uop_idx   <= {CNT_W{1'b0}};
               uop_first <= 1'b0;
               uop_last  <= 1'b0;
               done      <= 1'b1;
            end else begin
               uop_raA   <= uop_raA + REG_AW'(1'b1);
               uop_raB   <= uop_raB + REG_AW'(1'b1);
               uop_rdest <= uop_rdest + REG_AW'(1'b1);
               uop_idx   <= uop_idx + CNT_W'(1'b1);
               uop_first <= 1'b0;
               uop_last  <= ((uop_idx + CNT_W'(1'b1)) == last_idx_r);
            end
         end
      end
   end

endmodule

// File: tb/tb_vgroup_uop_sequencer.sv
// Randomized self-checking bench for vgroup_uop_sequencer against a per-group list model.
// Define VGROUP_VL_TRIM_EN on both files to exercise the vl-trim variant.
module tb_vgroup_uop_sequencer;

   logic       clock;
   logic       reset;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] in_raA;
   logic [4:0] in_raB;
   logic [4:0] in_rdest;
   logic [2:0] in_lmul;
   logic [3:0] in_vl_regs;
   logic       uop_valid;
   logic       uop_ready;
   logic [4:0] uop_raA;
   logic [4:0] uop_raB;
   logic [4:0] uop_rdest;
   logic [2:0] uop_idx;
   logic       uop_first;
   logic       uop_last;
   logic       stall_fetch;
   logic       done;
   logic       illegal_lmul;

   int vectors;
   int miscompares;

   vgroup_uop_sequencer #(.REG_AW(5), .CNT_W(3)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_raA(in_raA), .in_raB(in_raB), .in_rdest(in_rdest), .in_lmul(in_lmul),
`ifdef VGROUP_VL_TRIM_EN
      .in_vl_regs(in_vl_regs),
`endif
      .uop_valid(uop_valid), .uop_ready(uop_ready),
      .uop_raA(uop_raA), .uop_raB(uop_raB), .uop_rdest(uop_rdest),
      .uop_idx(uop_idx), .uop_first(uop_first), .uop_last(uop_last),
      .stall_fetch(stall_fetch), .done(done), .illegal_lmul(illegal_lmul)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Number of micro-ops the group must produce: 2^LMUL for integral LMUL, one for fractional.
   function automatic int model_count(input logic [2:0] lmul, input logic [3:0] vl);
      int n;
      if (lmul[2] == 1'b0) n = 1 << lmul[1:0];
      else n = 1;
`ifdef VGROUP_VL_TRIM_EN
      if (int'(vl) < n) n = int'(vl);
`endif
      return n;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Offers one group, drives uop_ready per mode (0 always, 1 random, 2 pattern 1,0,0) and checks every cycle.
   task automatic run_group(input logic [2:0] lmul, input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] d, input logic [3:0] vl, input int mode);
      int n, k, cyc;
      bit rdy, exp_stall;
      logic [4:0] ea, eb, ed;
      n = model_count(lmul, vl);
      in_valid = 1'b1; in_lmul = lmul; in_raA = a; in_raB = b; in_rdest = d; in_vl_regs = vl;
      uop_ready = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL accept_ready: got %0b expected 1", in_ready);
      end
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0; in_raA = 5'($urandom); in_raB = 5'($urandom); in_rdest = 5'($urandom);
      in_lmul = 3'($urandom);
      k = 0; cyc = 0;
      while (k < n && cyc < 200) begin
         case (mode)
            0: rdy = 1'b1;
            1: rdy = 1'($urandom);
            default: rdy = (cyc % 3 == 0);
         endcase
         uop_ready = rdy;
         #1;
         ea = a + 5'(k); eb = b + 5'(k); ed = d + 5'(k);
         exp_stall = !((k == n - 1) && rdy);
         vectors++;
         if (uop_valid !== 1'b1 || uop_idx !== 3'(k) || uop_raA !== ea || uop_raB !== eb ||
             uop_rdest !== ed || uop_first !== (k == 0) || uop_last !== (k == n - 1) ||
             stall_fetch !== exp_stall || in_ready !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL uop: got v=%0b idx=%0d a=%0d b=%0d d=%0d f=%0b l=%0b st=%0b rdy=%0b done=%0b expected v=1 idx=%0d a=%0d b=%0d d=%0d f=%0b l=%0b st=%0b rdy=0 done=0",
                     uop_valid, uop_idx, uop_raA, uop_raB, uop_rdest, uop_first, uop_last, stall_fetch,
                     in_ready, done, k, ea, eb, ed, (k == 0), (k == n - 1), exp_stall);
         end
         if (rdy) k++;
         @(negedge clock);
         cyc++;
      end
      if (cyc >= 200) begin
         vectors++; miscompares++;
         $display("FAIL handshake_budget: got %0d handshakes expected %0d", k, n);
      end
      uop_ready = 1'b0;
      #1;
      chk("done_pulse", done, 1);
      chk("valid_after_last", uop_valid, 0);
      chk("stall_after_last", stall_fetch, 0);
      chk("ready_after_last", in_ready, 1);
   endtask

   task automatic check_illegal();
      in_valid = 1'b1; in_lmul = 3'b100; in_raA = 5'($urandom); in_raB = 5'($urandom); in_rdest = 5'($urandom);
      in_vl_regs = 4'd8;
      #1;
      chk("illegal_accept_ready", in_ready, 1);
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      chk("illegal_pulse", illegal_lmul, 1);
      chk("illegal_no_valid", uop_valid, 0);
      chk("illegal_no_done", done, 0);
      chk("illegal_ready", in_ready, 1);
      chk("illegal_no_stall", stall_fetch, 0);
      @(negedge clock);
      #1;
      chk("illegal_pulse_end", illegal_lmul, 0);
      chk("illegal_still_idle", uop_valid, 0);
      chk("illegal_no_late_done", done, 0);
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; uop_ready = 1'b0;
      in_raA = 5'd0; in_raB = 5'd0; in_rdest = 5'd0; in_lmul = 3'd0; in_vl_regs = 4'd8;
      #1;
      chk("rst_valid", uop_valid, 0);
      chk("rst_idx", uop_idx, 0);
      chk("rst_first", uop_first, 0);
      chk("rst_last", uop_last, 0);
      chk("rst_stall", stall_fetch, 0);
      chk("rst_done", done, 0);
      chk("rst_illegal", illegal_lmul, 0);
      chk("rst_bases", {uop_raA, uop_raB, uop_rdest}, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rst_ready", in_ready, 1);
   endtask

   task automatic test_flush();
      in_valid = 1'b1; in_lmul = 3'b011; in_raA = 5'd4; in_raB = 5'd12; in_rdest = 5'd20; in_vl_regs = 4'd8;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0; uop_ready = 1'b1;
      @(negedge clock);
      @(negedge clock);
      #1;
      chk("flush_at_idx", uop_idx, 2);
      flush = 1'b1; in_valid = 1'b1; in_lmul = 3'b001;
      @(posedge clock);
      @(negedge clock);
      flush = 1'b0; in_valid = 1'b0; uop_ready = 1'b0;
      #1;
      chk("flush_valid", uop_valid, 0);
      chk("flush_idx", uop_idx, 0);
      chk("flush_no_done", done, 0);
      chk("flush_stall", stall_fetch, 0);
      chk("flush_ready", in_ready, 1);
      @(negedge clock);
      #1;
      chk("flush_no_late_done", done, 0);
      flush = 1'b1; in_valid = 1'b1; in_lmul = 3'b001;
      #1;
      chk("flush_blocks_ready", in_ready, 0);
      @(posedge clock);
      @(negedge clock);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("flush_drops_offer", uop_valid, 0);
      chk("flush_drop_no_done", done, 0);
      run_group(3'b011, 5'd1, 5'd2, 5'd3, 4'd8, 0);
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1; in_lmul = 3'b011; in_raA = 5'd9; in_raB = 5'd10; in_rdest = 5'd11; in_vl_regs = 4'd8;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0; uop_ready = 1'b1;
      @(negedge clock);
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", uop_valid, 0);
      chk("arst_idx", uop_idx, 0);
      chk("arst_flags", {uop_first, uop_last, stall_fetch, done, illegal_lmul}, 0);
      chk("arst_bases", {uop_raA, uop_raB, uop_rdest}, 0);
      @(negedge clock);
      reset = 1'b0; uop_ready = 1'b0;
      #1;
      chk("arst_ready", in_ready, 1);
      @(negedge clock);
      #1;
      chk("arst_no_done", done, 0);
      chk("arst_idle", uop_valid, 0);
   endtask

   task automatic test_back_to_back();
      run_group(3'b001, 5'd5, 5'd6, 5'd7, 4'd8, 1);
      run_group(3'b010, 5'd28, 5'd29, 5'd30, 4'd8, 0);
      run_group(3'b000, 5'd3, 5'd3, 5'd3, 4'd8, 0);
   endtask

   task automatic test_random();
      logic [2:0] lmul;
      for (int i = 0; i < 24; i++) begin
         lmul = 3'($urandom_range(0, 7));
         if (lmul == 3'b100) begin
            check_illegal();
         end else begin
            run_group(lmul, 5'($urandom), 5'($urandom), 5'($urandom),
                      4'($urandom_range(0, 15)), 1);
         end
         if ($urandom_range(0, 1) == 1) @(negedge clock);
      end
   endtask

`ifdef VGROUP_VL_TRIM_EN
   task automatic test_vl_trim();
      run_group(3'b011, 5'd0, 5'd8, 5'd16, 4'd3, 0);
      run_group(3'b011, 5'd0, 5'd8, 5'd16, 4'd0, 0);
   endtask
`endif

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      @(negedge clock);
      run_group(3'b011, 5'd8, 5'd16, 5'd24, 4'd8, 0);
      @(negedge clock);
      run_group(3'b010, 5'd1, 5'd2, 5'd3, 4'd8, 2);
      @(negedge clock);
      run_group(3'b001, 5'd30, 5'd7, 5'd31, 4'd8, 0);
      @(negedge clock);
      check_illegal();
      run_group(3'b110, 5'd2, 5'd4, 5'd6, 4'd8, 0);
      @(negedge clock);
      test_flush();
      @(negedge clock);
      test_async_reset();
      test_back_to_back();
`ifdef VGROUP_VL_TRIM_EN
      test_vl_trim();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
